// File: rtl/main_memory.sv
// Line-granular backing store behind the L1 cache: fixed-latency whole-line reads and writes,
// moved as BUS_BITS-wide beats over unidirectional request/response ports.
module main_memory #(
  parameter int ADDR_BITS  = 19,
  parameter int LINE_BYTES = 16,
  parameter int BUS_BITS   = 16,
  parameter int LATENCY    = 100
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [1:0]                              req_cmd,
  input  logic [ADDR_BITS-$clog2(LINE_BYTES)-1:0] req_addr,
  input  logic [BUS_BITS-1:0]                     req_data,
  output logic [1:0]                              resp_cmd,
  output logic [BUS_BITS-1:0]                     resp_data,
  output logic                                    busy,
  output logic                                    err
);
  localparam int LA_W      = ADDR_BITS - $clog2(LINE_BYTES);
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int BEATS     = LINE_BITS / BUS_BITS;
  localparam int BEAT_W    = $clog2(BEATS + 1);
  localparam int CNT_W     = $clog2(LATENCY);

  localparam logic [1:0] CMD_NOP   = 2'd0;
  localparam logic [1:0] CMD_RSV   = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_WRITE = 2'd3;
  localparam logic [1:0] RSP_NOP   = 2'd0;
  localparam logic [1:0] RSP_ACK   = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_COLLECT = 3'd1,
    S_WAIT       = 3'd2,
    S_RD_STREAM  = 3'd3,
    S_WR_ACK     = 3'd4
  } state_t;

  function automatic logic [BUS_BITS-1:0] beat_of(input logic [LINE_BITS-1:0] line, input int idx);
    logic [LINE_BITS-1:0] sh;
    sh = line >> (idx * BUS_BITS);
    return sh[BUS_BITS-1:0];
  endfunction

  function automatic logic [LINE_BITS-1:0] widen(input logic [BUS_BITS-1:0] d);
    logic [LINE_BITS-1:0] w;
    w = '0;
    w[BUS_BITS-1:0] = d;
    return w;
  endfunction

  logic [LINE_BITS-1:0] mem_q [0:(2**LA_W)-1];

  state_t               state_q, state_d;
  logic [LA_W-1:0]      addr_q, addr_d;
  logic                 is_wr_q, is_wr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [LINE_BITS-1:0] wbuf_q, wbuf_d;
  logic [1:0]           resp_cmd_q, resp_cmd_d;
  logic [BUS_BITS-1:0]  resp_data_q, resp_data_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 accept_s;
  logic                 mem_we_s;
  logic [LINE_BITS-1:0] rd_line_s;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    is_wr_d     = is_wr_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    wbuf_d      = wbuf_q;
    busy_d      = busy_q;
    err_d       = err_q;
    resp_cmd_d  = RSP_NOP;
    resp_data_d = '0;
    accept_s    = 1'b0;
    mem_we_s    = 1'b0;
    rd_line_s   = mem_q[addr_q];

    case (state_q)
      S_IDLE: begin
        accept_s = 1'b1;
      end
      S_WR_COLLECT: begin
        if (req_cmd == CMD_WRITE) begin
          wbuf_d = wbuf_q | (widen(req_data) << (int'(beat_q) * BUS_BITS));
          cnt_d  = cnt_q - CNT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = S_WAIT;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          beat_d  = '0;
        end
      end
      S_WAIT: begin
        if (req_cmd != CMD_NOP) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (cnt_q == '0) begin
          resp_cmd_d = RSP_ACK;
          if (is_wr_q) begin
            // Commit lands on the same edge that launches the ack, so any later read sees it.
            mem_we_s = 1'b1;
            state_d  = S_WR_ACK;
          end else begin
            resp_data_d = beat_of(rd_line_s, 0);
            beat_d      = BEAT_W'(1);
            state_d     = S_RD_STREAM;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RD_STREAM: begin
        if (beat_q == BEAT_W'(BEATS)) begin
          accept_s = 1'b1;
        end else begin
          if (req_cmd != CMD_NOP) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          resp_cmd_d  = RSP_ACK;
          resp_data_d = beat_of(rd_line_s, int'(beat_q));
          beat_d      = beat_q + BEAT_W'(1);
        end
      end
      S_WR_ACK: begin
        accept_s = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // The edge closing the last response cycle behaves like IDLE, allowing back-to-back commands.
    if (accept_s) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      beat_d  = '0;
      case (req_cmd)
        CMD_READ: begin
          addr_d  = req_addr;
          is_wr_d = 1'b0;
          cnt_d   = CNT_W'(LATENCY - 2);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
        CMD_WRITE: begin
          addr_d  = req_addr;
          is_wr_d = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 2);
          wbuf_d  = widen(req_data);
          beat_d  = BEAT_W'(1);
          busy_d  = 1'b1;
          state_d = S_WR_COLLECT;
        end
        CMD_RSV: begin
          err_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      accept_s = 1'b0;
    end
  end

  // Control state and registered outputs; storage is deliberately outside the reset domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      is_wr_q     <= 1'b0;
      cnt_q       <= '0;
      beat_q      <= '0;
      wbuf_q      <= '0;
      resp_cmd_q  <= RSP_NOP;
      resp_data_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      is_wr_q     <= is_wr_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      wbuf_q      <= wbuf_d;
      resp_cmd_q  <= resp_cmd_d;
      resp_data_q <= resp_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Whole-line commit in a single edge; an abandoned write never reaches this port.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= wbuf_q;
    end
  end

  assign resp_cmd  = resp_cmd_q;
  assign resp_data = resp_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: directed scenarios plus random traffic, checked every cycle against
// a transaction-level schedule of expected responses derived from the line-store rules.
module tb_main_memory;
  localparam int NCYC = 8192;
  localparam int LAT  = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req_cmd = 2'd0;
  logic [14:0] req_addr = 15'd0;
  logic [15:0] req_data = 16'd0;
  logic [1:0]  resp_cmd;
  logic [15:0] resp_data;
  logic        busy;
  logic        err;

  main_memory dut (
    .clk(clk), .reset(reset), .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
    .resp_cmd(resp_cmd), .resp_data(resp_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Expected outputs visible just after edge number e.
  logic        exp_cmd  [NCYC];
  logic [15:0] exp_dat  [NCYC];
  logic        exp_busy [NCYC];

  logic [127:0] mem_m [logic [14:0]];
  int           m_busy_until = 0;
  bit           m_in_write = 1'b0;
  int           m_wr_t0 = 0;
  logic [14:0]  m_wr_addr = 15'd0;
  logic [127:0] m_buf = 128'd0;
  bit           m_pend = 1'b0;
  int           m_pend_edge = 0;
  logic [14:0]  m_pend_addr = 15'd0;
  logic [127:0] m_pend_line = 128'd0;
  bit           m_err = 1'b0;

  logic [14:0]  pool [4] = '{15'h0005, 15'h7FFF, 15'h0000, 15'h2A55};
  logic [127:0] t2_line;
  logic [127:0] rnd_line;

  task automatic chk(input string tag, input int e, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s edge %0d: observed %h expected %h", tag, e, got, want);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [14:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    else return 128'd0;
  endfunction

  task automatic model_edge(input int e, input logic [1:0] c, input logic [14:0] a, input logic [15:0] d);
    int k;
    logic [127:0] line;
    if (m_pend && e >= m_pend_edge) begin
      mem_m[m_pend_addr] = m_pend_line;
      m_pend = 1'b0;
    end
    if (m_in_write) begin
      k = e - m_wr_t0;
      if (c == 2'd3) begin
        m_buf[k*16 +: 16] = d;
        exp_busy[e] = 1'b1;
        if (k == 7) begin
          for (int j = e; j <= m_wr_t0 + LAT - 1; j++) exp_busy[j] = 1'b1;
          exp_cmd[m_wr_t0 + LAT - 1] = 1'b1;
          exp_dat[m_wr_t0 + LAT - 1] = 16'd0;
          m_pend = 1'b1;
          m_pend_edge = m_wr_t0 + LAT - 1;
          m_pend_addr = m_wr_addr;
          m_pend_line = m_buf;
          m_busy_until = m_wr_t0 + LAT - 1;
          m_in_write = 1'b0;
        end
      end else begin
        m_err = 1'b1;
        m_in_write = 1'b0;
        m_busy_until = e;
      end
    end else if (e <= m_busy_until) begin
      if (c != 2'd0) m_err = 1'b1;
    end else begin
      case (c)
        2'd2: begin
          line = line_of(a);
          for (int j = 0; j < 8; j++) begin
            exp_cmd[e + LAT - 1 + j] = 1'b1;
            exp_dat[e + LAT - 1 + j] = line[j*16 +: 16];
          end
          for (int j = e; j <= e + LAT + 6; j++) exp_busy[j] = 1'b1;
          m_busy_until = e + LAT + 6;
        end
        2'd3: begin
          m_in_write = 1'b1;
          m_wr_t0 = e;
          m_wr_addr = a;
          m_buf = 128'd0;
          m_buf[15:0] = d;
          exp_busy[e] = 1'b1;
        end
        2'd1: m_err = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic [1:0] c, input logic [14:0] a, input logic [15:0] d);
    int e;
    req_cmd = c;
    req_addr = a;
    req_data = d;
    @(posedge clk);
    cyc++;
    e = cyc;
    model_edge(e, c, a, d);
    @(negedge clk);
    chk("resp_cmd", e, {30'd0, resp_cmd}, {31'd0, exp_cmd[e]});
    chk("resp_data", e, {16'd0, resp_data}, {16'd0, exp_dat[e]});
    chk("busy", e, {31'd0, busy}, {31'd0, exp_busy[e]});
    chk("err", e, {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'd0, 15'd0, 16'd0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_resp_cmd", cyc, {30'd0, resp_cmd}, 32'd0);
    chk("rst_resp_data", cyc, {16'd0, resp_data}, 32'd0);
    chk("rst_busy", cyc, {31'd0, busy}, 32'd0);
    chk("rst_err", cyc, {31'd0, err}, 32'd0);
    #1 reset = 1'b0;
    for (int j = cyc + 1; j < NCYC; j++) begin
      exp_cmd[j] = 1'b0;
      exp_dat[j] = 16'd0;
      exp_busy[j] = 1'b0;
    end
    if (m_pend && cyc >= m_pend_edge) mem_m[m_pend_addr] = m_pend_line;
    m_pend = 1'b0;
    m_in_write = 1'b0;
    m_busy_until = cyc;
    m_err = 1'b0;
  endtask

  task automatic wr_line(input logic [14:0] a, input logic [127:0] line, input int drop_at);
    for (int k = 0; k < 8; k++) begin
      if (k == drop_at) begin
        step(2'd0, a, 16'd0);
        break;
      end
      step(2'd3, a, line[k*16 +: 16]);
    end
  endtask

  initial begin
    logic [1:0] c;
    int r;
    for (int j = 0; j < NCYC; j++) begin
      exp_cmd[j] = 1'b0;
      exp_dat[j] = 16'd0;
      exp_busy[j] = 1'b0;
    end
    for (int k = 0; k < 8; k++) t2_line[k*16 +: 16] = {8'((2*k+1)*17), 8'((2*k)*17)};

    do_reset();

    // T3: never-written line reads back as zeros at the exact response window.
    step(2'd2, 15'h7FFF, 16'd0);
    idle(110);

    // T2: write then read back the same line.
    wr_line(15'h0005, t2_line, 8);
    idle(100);
    step(2'd2, 15'h0005, 16'd0);
    idle(110);

    // T1: reset while a read is waiting; no beats appear, the next read works.
    step(2'd2, 15'h0005, 16'd0);
    idle(50);
    do_reset();
    idle(120);
    step(2'd2, 15'h0005, 16'd0);
    idle(110);

    // T4: write aborted on beat 3 leaves the line untouched and raises err.
    rnd_line = {$urandom, $urandom, $urandom, $urandom};
    wr_line(15'h0005, rnd_line, 3);
    idle(3);
    step(2'd2, 15'h0005, 16'd0);
    idle(110);
    do_reset();

    // T5: read during a read is ignored; back-to-back read right after the last beat.
    step(2'd2, 15'h0005, 16'd0);
    idle(49);
    step(2'd2, 15'h7FFF, 16'd0);
    idle(56);
    step(2'd2, 15'h2A55, 16'd0);
    idle(110);
    do_reset();

    // Random traffic over a small address pool so lines get rewritten and reread.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else if (m_in_write) begin
        if ($urandom_range(0, 15) == 0) c = 2'($urandom_range(0, 2));
        else c = 2'd3;
        step(c, pool[$urandom_range(0, 3)], 16'($urandom));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 4) c = 2'd2;
        else if (r < 8) c = 2'd3;
        else if (r < 9) c = 2'd1;
        else if (r < 11) c = 2'($urandom_range(1, 3));
        else c = 2'd0;
        step(c, pool[$urandom_range(0, 3)], 16'($urandom));
      end
    end
    idle(120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
